// File: rtl/axi_to_ready_valid.sv
// AXI4-Lite slave that forwards single-beat accesses to word 0 onto a user-side
// ready/valid port "A"; the AXI response waits for the user side to finish.
module axi_to_ready_valid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              S00_AXI_aclk,
    input  logic              S00_AXI_aresetn,
    input  logic [ADDR_W-1:0] S00_AXI_awaddr,
    input  logic              S00_AXI_awvalid,
    output logic              S00_AXI_awready,
    input  logic [DATA_W-1:0] S00_AXI_wdata,
    input  logic              S00_AXI_wvalid,
    output logic              S00_AXI_wready,
    output logic              S00_AXI_bvalid,
    input  logic              S00_AXI_bready,
    output logic [1:0]        S00_AXI_bresp,
    input  logic [ADDR_W-1:0] S00_AXI_araddr,
    input  logic              S00_AXI_arvalid,
    output logic              S00_AXI_arready,
    output logic              S00_AXI_rvalid,
    input  logic              S00_AXI_rready,
    output logic [DATA_W-1:0] S00_AXI_rdata,
    output logic [1:0]        S00_AXI_rresp,
    output logic              A_wvalid_o,
    input  logic              A_wready_i,
    output logic [DATA_W-1:0] A_wdata_o,
    input  logic              A_werror_i,
    output logic              A_rready_o,
    input  logic              A_rvalid_i,
    input  logic [DATA_W-1:0] A_rdata_i,
    input  logic              A_rerror_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_USER,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_USER,
        R_RESP
    } r_state_t;

    // Only word 0 is backed by the user port; everything else decodes to DECERR.
    function automatic logic is_word0(input logic [ADDR_W-1:0] addr);
        return (addr >> 2) == '0;
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t          w_state_reg, w_state_next;
    logic              awready_reg, awready_next;
    logic              wready_reg, wready_next;
    logic              aw_done_reg, aw_done_next;
    logic              w_done_reg, w_done_next;
    logic              aw_word0_reg, aw_word0_next;
    logic              a_wvalid_reg, a_wvalid_next;
    logic [DATA_W-1:0] a_wdata_reg, a_wdata_next;
    logic              bvalid_reg, bvalid_next;
    logic [1:0]        bresp_reg, bresp_next;

    logic aw_hs;
    logic w_hs;
    logic aw_have;
    logic w_have;
    logic wr_word0;

    assign aw_hs    = awready_reg & S00_AXI_awvalid;
    assign w_hs     = wready_reg & S00_AXI_wvalid;
    assign aw_have  = aw_done_reg | aw_hs;
    assign w_have   = w_done_reg | w_hs;
    assign wr_word0 = aw_hs ? is_word0(S00_AXI_awaddr) : aw_word0_reg;

    always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
        if (!S00_AXI_aresetn) begin
            w_state_reg  <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            aw_word0_reg <= 1'b0;
            a_wvalid_reg <= 1'b0;
            a_wdata_reg  <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            w_state_reg  <= w_state_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            aw_done_reg  <= aw_done_next;
            w_done_reg   <= w_done_next;
            aw_word0_reg <= aw_word0_next;
            a_wvalid_reg <= a_wvalid_next;
            a_wdata_reg  <= a_wdata_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
        end
    end

    always_comb begin
        w_state_next  = w_state_reg;
        awready_next  = awready_reg;
        wready_next   = wready_reg;
        aw_done_next  = aw_done_reg;
        w_done_next   = w_done_reg;
        aw_word0_next = aw_word0_reg;
        a_wvalid_next = a_wvalid_reg;
        a_wdata_next  = a_wdata_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;

        case (w_state_reg)
            W_IDLE: begin
                // AW and W are collected independently; either may arrive first.
                if (aw_hs) begin
                    awready_next  = 1'b0;
                    aw_done_next  = 1'b1;
                    aw_word0_next = is_word0(S00_AXI_awaddr);
                end else if (!aw_done_reg) begin
                    awready_next = 1'b1;
                end

                if (w_hs) begin
                    wready_next  = 1'b0;
                    w_done_next  = 1'b1;
                    a_wdata_next = S00_AXI_wdata;
                end else if (!w_done_reg) begin
                    wready_next = 1'b1;
                end

                if (aw_have && w_have) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    awready_next = 1'b0;
                    wready_next  = 1'b0;
                    if (wr_word0) begin
                        w_state_next  = W_USER;
                        a_wvalid_next = 1'b1;
                    end else begin
                        w_state_next = W_RESP;
                        bvalid_next  = 1'b1;
                        bresp_next   = RESP_DECERR;
                    end
                end
            end

            W_USER: begin
                if (A_wready_i) begin
                    a_wvalid_next = 1'b0;
                    bvalid_next   = 1'b1;
                    bresp_next    = A_werror_i ? RESP_SLVERR : RESP_OKAY;
                    w_state_next  = W_RESP;
                end
            end

            W_RESP: begin
                if (S00_AXI_bready) begin
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                    w_state_next = W_IDLE;
                end
            end

            default: begin
                w_state_next  = W_IDLE;
                awready_next  = 1'b0;
                wready_next   = 1'b0;
                aw_done_next  = 1'b0;
                w_done_next   = 1'b0;
                a_wvalid_next = 1'b0;
                bvalid_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read path (fully independent of the write path)
    // ------------------------------------------------------------------
    r_state_t          r_state_reg, r_state_next;
    logic              arready_reg, arready_next;
    logic              a_rready_reg, a_rready_next;
    logic              rvalid_reg, rvalid_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [1:0]        rresp_reg, rresp_next;

    logic ar_hs;

    assign ar_hs = arready_reg & S00_AXI_arvalid;

    always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
        if (!S00_AXI_aresetn) begin
            r_state_reg  <= R_IDLE;
            arready_reg  <= 1'b0;
            a_rready_reg <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
        end else begin
            r_state_reg  <= r_state_next;
            arready_reg  <= arready_next;
            a_rready_reg <= a_rready_next;
            rvalid_reg   <= rvalid_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
        end
    end

    always_comb begin
        r_state_next  = r_state_reg;
        arready_next  = arready_reg;
        a_rready_next = a_rready_reg;
        rvalid_next   = rvalid_reg;
        rdata_next    = rdata_reg;
        rresp_next    = rresp_reg;

        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    arready_next = 1'b0;
                    if (is_word0(S00_AXI_araddr)) begin
                        r_state_next  = R_USER;
                        a_rready_next = 1'b1;
                    end else begin
                        r_state_next = R_RESP;
                        rvalid_next  = 1'b1;
                        rdata_next   = '0;
                        rresp_next   = RESP_DECERR;
                    end
                end else begin
                    arready_next = 1'b1;
                end
            end

            R_USER: begin
                if (A_rvalid_i) begin
                    a_rready_next = 1'b0;
                    rvalid_next   = 1'b1;
                    rdata_next    = A_rdata_i;
                    rresp_next    = A_rerror_i ? RESP_SLVERR : RESP_OKAY;
                    r_state_next  = R_RESP;
                end
            end

            R_RESP: begin
                if (S00_AXI_rready) begin
                    rvalid_next  = 1'b0;
                    arready_next = 1'b1;
                    r_state_next = R_IDLE;
                end
            end

            default: begin
                r_state_next  = R_IDLE;
                arready_next  = 1'b0;
                a_rready_next = 1'b0;
                rvalid_next   = 1'b0;
            end
        endcase
    end

    assign S00_AXI_awready = awready_reg;
    assign S00_AXI_wready  = wready_reg;
    assign S00_AXI_bvalid  = bvalid_reg;
    assign S00_AXI_bresp   = bresp_reg;
    assign S00_AXI_arready = arready_reg;
    assign S00_AXI_rvalid  = rvalid_reg;
    assign S00_AXI_rdata   = rdata_reg;
    assign S00_AXI_rresp   = rresp_reg;
    assign A_wvalid_o      = a_wvalid_reg;
    assign A_wdata_o       = a_wdata_reg;
    assign A_rready_o      = a_rready_reg;

endmodule

// File: tb/tb_axi_to_ready_valid.sv
// Randomized scoreboard bench for axi_to_ready_valid: stimulus pushes expected
// user-side transfers and AXI responses, monitors pop and compare.
module tb_axi_to_ready_valid;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int LIMIT  = 300;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [1:0]        bresp;
    logic [ADDR_W-1:0] araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              a_wvalid;
    logic              a_wready = 1'b0;
    logic [DATA_W-1:0] a_wdata;
    logic              a_werror = 1'b0;
    logic              a_rready;
    logic              a_rvalid = 1'b0;
    logic [DATA_W-1:0] a_rdata = '0;
    logic              a_rerror = 1'b0;

    always #5 clk = ~clk;

    axi_to_ready_valid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .S00_AXI_aclk(clk),       .S00_AXI_aresetn(rst_n),
        .S00_AXI_awaddr(awaddr),  .S00_AXI_awvalid(awvalid), .S00_AXI_awready(awready),
        .S00_AXI_wdata(wdata),    .S00_AXI_wvalid(wvalid),   .S00_AXI_wready(wready),
        .S00_AXI_bvalid(bvalid),  .S00_AXI_bready(bready),   .S00_AXI_bresp(bresp),
        .S00_AXI_araddr(araddr),  .S00_AXI_arvalid(arvalid), .S00_AXI_arready(arready),
        .S00_AXI_rvalid(rvalid),  .S00_AXI_rready(rready),   .S00_AXI_rdata(rdata),
        .S00_AXI_rresp(rresp),
        .A_wvalid_o(a_wvalid),    .A_wready_i(a_wready),     .A_wdata_o(a_wdata),
        .A_werror_i(a_werror),
        .A_rready_o(a_rready),    .A_rvalid_i(a_rvalid),     .A_rdata_i(a_rdata),
        .A_rerror_i(a_rerror)
    );

    typedef struct packed {logic err; logic [DATA_W-1:0] data;} rd_item_t;
    typedef struct packed {logic [1:0] resp; logic [DATA_W-1:0] data;} r_exp_t;

    logic [DATA_W-1:0] exp_aw_q[$];
    logic              werr_q[$];
    logic [1:0]        exp_b_q[$];
    rd_item_t          rd_q[$];
    r_exp_t            exp_r_q[$];

    int tests = 0;
    int fails = 0;
    int a_w_seen = 0, a_w_exp = 0, a_r_seen = 0, a_r_exp = 0;
    bit hold_w = 0, hold_rr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference rule: byte address / 4 selects the word; only word 0 reaches A.
    function automatic bit maps_to_user(input int addr);
        return (addr / 4) == 0;
    endfunction

    // User-side write responder.
    initial forever begin
        @(posedge clk); #1;
        if (rst_n && a_wvalid && !a_wready && !hold_w && werr_q.size() > 0 &&
            $urandom_range(0, 2) != 0) begin
            a_wready = 1'b1;
            a_werror = werr_q.pop_front();
        end else begin
            a_wready = 1'b0;
            a_werror = 1'($urandom);
        end
    end

    // User-side read responder.
    initial forever begin
        rd_item_t it;
        @(posedge clk); #1;
        if (rst_n && a_rready && !a_rvalid && rd_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            it = rd_q.pop_front();
            a_rvalid = 1'b1;
            a_rdata  = it.data;
            a_rerror = it.err;
        end else begin
            a_rvalid = 1'b0;
            a_rdata  = $urandom;
            a_rerror = 1'($urandom);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        bready = ($urandom_range(0, 3) != 0);
        rready = !hold_rr && ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (a_wvalid) begin
                if (exp_aw_q.size() == 0) check("a_w_spurious", a_wvalid, 1'b0);
                else begin
                    check("a_wdata", a_wdata, exp_aw_q[0]);
                    if (a_wready) begin
                        void'(exp_aw_q.pop_front());
                        a_w_seen++;
                    end
                end
            end
            if (a_rready && !a_rvalid && rd_q.size() == 0)
                check("a_r_spurious", a_rready, 1'b0);
            if (a_rready && a_rvalid) a_r_seen++;
            if (bvalid) begin
                if (exp_b_q.size() == 0) check("b_spurious", bvalid, 1'b0);
                else begin
                    check("bresp", bresp, exp_b_q[0]);
                    if (bready) void'(exp_b_q.pop_front());
                end
            end
            if (rvalid) begin
                if (exp_r_q.size() == 0) check("r_spurious", rvalid, 1'b0);
                else begin
                    check("rresp_rdata", {rresp, rdata}, exp_r_q[0]);
                    if (rready) void'(exp_r_q.pop_front());
                end
            end
        end
    end

    task automatic send_aw(input logic [ADDR_W-1:0] addr);
        int n = 0;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        while (!awready && n < LIMIT) begin @(negedge clk); n++; end
        check("aw_handshake_in_time", n < LIMIT, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; awaddr = ADDR_W'($urandom);
    endtask

    task automatic send_w(input logic [DATA_W-1:0] data);
        int n = 0;
        @(negedge clk);
        wdata = data; wvalid = 1'b1;
        while (!wready && n < LIMIT) begin @(negedge clk); n++; end
        check("w_handshake_in_time", n < LIMIT, 1'b1);
        @(negedge clk);
        wvalid = 1'b0; wdata = $urandom;
    endtask

    task automatic send_ar(input logic [ADDR_W-1:0] addr);
        int n = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        while (!arready && n < LIMIT) begin @(negedge clk); n++; end
        check("ar_handshake_in_time", n < LIMIT, 1'b1);
        @(negedge clk);
        arvalid = 1'b0; araddr = ADDR_W'($urandom);
    endtask

    task automatic axi_write(input int addr, input logic [DATA_W-1:0] data, input logic err,
                             input int aw_dly, input int w_dly, input bit wait_b);
        int n = 0;
        if (maps_to_user(addr)) begin
            exp_aw_q.push_back(data);
            werr_q.push_back(err);
            exp_b_q.push_back(err ? 2'b10 : 2'b00);
            a_w_exp++;
        end else begin
            exp_b_q.push_back(2'b11);
        end
        fork
            begin repeat (aw_dly) @(negedge clk); send_aw(ADDR_W'(addr)); end
            begin repeat (w_dly) @(negedge clk); send_w(data); end
        join
        if (wait_b) begin
            while (exp_b_q.size() != 0 && n < LIMIT) begin @(negedge clk); n++; end
            check("b_done_in_time", n < LIMIT, 1'b1);
        end
    endtask

    task automatic axi_read(input int addr, input logic [DATA_W-1:0] data, input logic err,
                            input int dly, input bit wait_r);
        int n = 0;
        if (maps_to_user(addr)) begin
            rd_q.push_back('{err: err, data: data});
            exp_r_q.push_back('{resp: (err ? 2'b10 : 2'b00), data: data});
            a_r_exp++;
        end else begin
            exp_r_q.push_back('{resp: 2'b11, data: '0});
        end
        repeat (dly) @(negedge clk);
        send_ar(ADDR_W'(addr));
        if (wait_r) begin
            while (exp_r_q.size() != 0 && n < LIMIT) begin @(negedge clk); n++; end
            check("r_done_in_time", n < LIMIT, 1'b1);
        end
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 2) != 0) return $urandom_range(0, 3);
        return $urandom_range(4, 15);
    endfunction

    initial begin
        int w0, r0, n;
        #12;
        check("reset_valids", {awready, wready, arready, bvalid, rvalid, a_wvalid, a_rready}, 7'b0);
        check("reset_data", {bresp, rresp, rdata, a_wdata}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {awready, wready, arready}, 3'b111);

        // AW held, W pulsed 5 clocks later; then a plain read.
        axi_write(0, 32'hDEADBEEF, 1'b0, 0, 5, 1);
        axi_read(0, 32'h12345678, 1'b0, 0, 1);

        // W before AW, AW in the same cycle as AR: one A write, one A read.
        w0 = a_w_seen; r0 = a_r_seen;
        fork
            axi_write(0, 32'hA5A55A5A, 1'b0, 3, 0, 1);
            axi_read(0, 32'h0BADF00D, 1'b0, 3, 1);
        join
        check("one_a_write", a_w_seen - w0, 1);
        check("one_a_read", a_r_seen - r0, 1);

        // Error and decode-error cases.
        axi_write(0, 32'h11112222, 1'b1, 0, 0, 1);
        axi_read(0, 32'h33334444, 1'b1, 0, 1);
        w0 = a_w_seen; r0 = a_r_seen;
        axi_write(4, 32'h55556666, 1'b0, 0, 0, 1);
        axi_read(4, 32'h77778888, 1'b0, 0, 1);
        check("no_a_write_addr4", a_w_seen - w0, 0);
        check("no_a_read_addr4", a_r_seen - r0, 0);

        // Randomized concurrent traffic.
        for (int i = 0; i < 60; i++) begin
            fork
                axi_write(rand_addr(), $urandom, 1'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), 1);
                axi_read(rand_addr(), $urandom, 1'($urandom), $urandom_range(0, 3), 1);
            join
        end

        // Asynchronous reset with a user write and a read response in flight.
        hold_w = 1; hold_rr = 1;
        fork
            axi_write(0, 32'hCAFEF00D, 1'b0, 0, 0, 0);
            axi_read(4, 32'h0, 1'b0, 0, 0);
        join
        n = 0;
        while (!(a_wvalid && rvalid) && n < LIMIT) begin @(negedge clk); n++; end
        check("inflight_before_reset", n < LIMIT, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valids", {bvalid, rvalid, a_wvalid, a_rready, awready, wready, arready}, 7'b0);
        check("async_reset_data", {bresp, rresp, rdata, a_wdata}, '0);
        exp_aw_q.delete(); werr_q.delete(); exp_b_q.delete(); rd_q.delete(); exp_r_q.delete();
        a_w_exp = a_w_seen; a_r_exp = a_r_seen;
        hold_w = 0; hold_rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi_write(0, 32'h600DCAFE, 1'b0, 1, 0, 1);
        axi_read(0, 32'hFEEDFACE, 1'b0, 0, 1);

        repeat (5) @(negedge clk);
        check("a_write_count", a_w_seen, a_w_exp);
        check("a_read_count", a_r_seen, a_r_exp);
        check("queues_drained", exp_aw_q.size() + exp_b_q.size() + exp_r_q.size() + rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
